// File: rtl/desempacotador_if.sv
// Packed-register consumer bus: command, packed input side, decoded output side, error status.
// Carries no state; every signal is owned by either the producer/consumer or the decoder.
// in_valid/in_ready on the input side, out_valid/out_ready on the output side.
interface desempacotador_if #(
  parameter int CNT_W = 8
);
  logic [1:0]       T;
  logic [5:0]       in;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       out;
  logic             out_valid;
  logic             out_ready;
  logic             erro;
  logic [CNT_W-1:0] erro_cnt;

  // Producer/consumer side: drives command, packed word and consumer ready.
  modport master (
    output T, in, in_valid, out_ready,
    input  in_ready, out, out_valid, erro, erro_cnt
  );

  // Decoder side.
  modport slave (
    input  T, in, in_valid, out_ready,
    output in_ready, out, out_valid, erro, erro_cnt
  );
endinterface

// File: rtl/desempacotador.sv
// Decodes 6-bit packed words {v4,0,v3..v0} into 5-bit values and queues them in a small FIFO.
// Latency 1 cycle: a word accepted at edge N is at the head after edge N when the FIFO was empty.
// in_ready drops when full, on clear/hold or in reset; no pass-through when full; output drains independently.
// Optional macro DESEMPACOTADOR_ERRO_EN: drop words with bit 4 set and flag/count them.
module desempacotador #(
  parameter int PROFUNDIDADE = 2,
  parameter int CNT_W        = 8
) (
  input logic                clk,
  input logic                reset,
  desempacotador_if.slave    bus
);

  localparam int AW = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1;
  localparam int CW = $clog2(PROFUNDIDADE + 1);

  logic [4:0]       mem [PROFUNDIDADE];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;

  logic             clear;
  logic             accept;
  logic             push;
  logic             pop;
  logic [4:0]       value;

  assign clear  = (bus.T == 2'b00);
  assign value  = {bus.in[5], bus.in[3:0]};

  // Ready depends only on registered occupancy, the command and reset.
  assign bus.in_ready  = !reset && (bus.T == 2'b01) && (count < CW'(PROFUNDIDADE));
  assign accept        = bus.in_valid && bus.in_ready;
  assign bus.out_valid = (count != '0);
  assign bus.out       = bus.out_valid ? mem[rd_ptr] : 5'd0;
  // A clear cycle discards any pop requested alongside it.
  assign pop           = bus.out_valid && bus.out_ready && !clear;

`ifdef DESEMPACOTADOR_ERRO_EN
  logic             erro_q;
  logic [CNT_W-1:0] erro_cnt_q;
  logic             malformed;

  assign malformed = accept && bus.in[4];
  // Malformed words complete the handshake but never enter the FIFO.
  assign push      = accept && !bus.in[4];

  // Sticky error flag and saturating error counter; only reset clears them.
  always_ff @(posedge clk) begin
    if (reset) begin
      erro_q     <= 1'b0;
      erro_cnt_q <= '0;
    end else if (malformed) begin
      erro_q <= 1'b1;
      if (erro_cnt_q != '1) erro_cnt_q <= erro_cnt_q + 1'b1;
    end
  end

  assign bus.erro     = erro_q;
  assign bus.erro_cnt = erro_cnt_q;
`else
  logic unused_bit4;

  // Bit 4 is don't-care in this build; every accepted word is queued.
  assign unused_bit4  = bus.in[4];
  assign push         = accept;
  assign bus.erro     = 1'b0;
  assign bus.erro_cnt = '0;
`endif

  // Pointer and occupancy update; reset takes priority over clear.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage write; contents past count are never observed, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= value;
  end

endmodule

// File: doc/desempacotador.md
# desempacotador

Decodes the 6-bit packed register format back into its 5-bit value: packed word {v4, 1'b0, v3, v2, v1, v0} → value {v4, v3, v2, v1, v0}. Sits on the consumer side of the packed-register path and buffers decoded values in a small FIFO with valid/ready handshakes on both sides. Uses the same 2-bit T command encoding as the packing register (00 clear, 01 load). Optionally checks the always-zero bit 4 and counts malformed words.

## Interface

- PROFUNDIDADE, default 2: FIFO depth in entries; power of two, legal range 2..8.
- CNT_W, default 8: width of the error counter.

- clk  in  1  clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- T  in  2  command: 2'b00 clear, 2'b01 load/decode, 2'b10 and 2'b11 hold.
- in  in  6  packed input word.
- in_valid  in  1  `in` holds a word to be accepted.
- in_ready  out  1  block accepts `in` this cycle.
- out  out  5  decoded value at the FIFO head; 5'd0 when the FIFO is empty.
- out_valid  out  1  FIFO is non-empty.
- out_ready  in  1  consumer takes the head entry this cycle.
- erro  out  1  sticky flag: a malformed word has been seen.
- erro_cnt  out  CNT_W  saturating count of malformed words.

## Operation

- Decode: value = {in[5], in[3:0]}. A word is malformed when in[4] = 1.
- Accept: push occurs when in_valid && in_ready.
- in_ready = !reset && (T == 2'b01) && (count < PROFUNDIDADE).
  - Combinational from registered count, T, and reset.
  - A full FIFO never accepts, even if a pop occurs in the same cycle (no pass-through).
- Pop: occurs when out_valid && out_ready. It is independent of T except during clear.
- Push and pop in the same cycle (FIFO non-empty and not full): count is unchanged and order is preserved.
- FIFO: read and write pointers wrap modulo PROFUNDIDADE. Count has range 0..PROFUNDIDADE.
- T = 2'b00 (clear):
  - Next edge: count = 0, pointers = 0, out_valid = 0, out = 0.
  - Any pop requested in that cycle is discarded.
  - erro and erro_cnt are retained.
- T = 2'b10 / 2'b11 (hold): in_ready = 0. The output side keeps draining normally.
- reset has priority over T. At the next edge, all of the following are 0: count, pointers, out, out_valid, in_ready, erro, erro_cnt. A reset in the middle of traffic discards all buffered entries.

## Timing

- Latency is 1 cycle. A word accepted at edge N appears at the head after edge N when the FIFO was empty: out_valid = 1, out = value.
- out_valid and out come from registered state only, with no combinational path from `in`.
- erro and erro_cnt update on the same edge as the offending acceptance.
- Reset values:
  - out = 5'd0
  - out_valid = 0
  - in_ready = 0 while reset is high
  - erro = 0
  - erro_cnt = 0
- erro_cnt saturates at 2^CNT_W − 1 and does not wrap.

## Configuration

- Macro: DESEMPACOTADOR_ERRO_EN.
- When defined:
  - A malformed word is still handshaked (in_ready unchanged) but is dropped, not pushed.
  - erro is set and erro_cnt is incremented (saturating).
- When undefined:
  - in[4] is ignored and every accepted word is decoded and pushed.
  - erro is tied to 0 and erro_cnt to 0.
  - Ports are identical in both builds.

## Test plan

1. Reset, then T = 01, in = 6'b100101, in_valid = 1 for one cycle → the cycle after acceptance: out_valid = 1, out = 5'b10101; with out_ready = 1 for one cycle → out_valid = 0, out = 0.
2. PROFUNDIDADE = 2, out_ready = 0, push 6'b000001 then 6'b000010 → in_ready = 0 with count = 2; a third word is held and not accepted; pops return 5'd1 then 5'd2.
3. Malformed in = 6'b010011 with DESEMPACOTADOR_ERRO_EN → out_valid stays 0, erro = 1, erro_cnt = 1. Without the macro → out = 5'b00011, out_valid = 1, erro = 0.
4. Two entries queued, T = 00 for one cycle → next cycle out_valid = 0, out = 0, erro and erro_cnt unchanged. Then assert reset → erro = 0, erro_cnt = 0.
5. One entry queued; push 6'b000111 while popping in the same cycle → count stays 1, out = 5'b00111 next cycle.
6. CNT_W = 8, 300 consecutive malformed words with DESEMPACOTADOR_ERRO_EN → erro_cnt = 255, FIFO stays empty.
